// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM substate encodings plus the per-substate qualification rules
// (pass class, target count, ms limit, exit code) used by the RX sequencer.
package pcie_ltssm_pkg;

  typedef enum logic [4:0] {
    detectQuiet          = 5'd0,
    detectActive         = 5'd1,
    pollingActive        = 5'd2,
    pollingConfiguration = 5'd3,
    cfgLinkWidthStart    = 5'd4,
    cfgLinkWidthAccept   = 5'd5,
    cfgLanenumWait       = 5'd6,
    cfgLanenumAccept     = 5'd7,
    cfgComplete          = 5'd8,
    cfgIdle              = 5'd9,
    recoveryRcvrLock     = 5'd10,
    recoveryRcvrCfg      = 5'd11,
    recoveryIdle         = 5'd12,
    recoverySpeed        = 5'd13,
    recoveryWait         = 5'd14,
    recoverySpeedEIEOS   = 5'd15,
    phase0               = 5'd16,
    phase1               = 5'd17,
    phase2               = 5'd18,
    phase3               = 5'd19,
    L0                   = 5'd20
  } substate_e;

  typedef enum logic [2:0] {stIdle, stArm, stCount, stPass, stFail} seqState_e;

  typedef enum logic [2:0] {
    qualCount, qualSpeed, qualDetQuiet, qualDetActive, qualFail
  } qualClass_e;

  localparam int MS_W = 6;
  localparam logic [MS_W-1:0] LIMIT_0MS  = 6'd0;
  localparam logic [MS_W-1:0] LIMIT_2MS  = 6'd2;
  localparam logic [MS_W-1:0] LIMIT_12MS = 6'd12;
  localparam logic [MS_W-1:0] LIMIT_24MS = 6'd24;
  localparam logic [MS_W-1:0] LIMIT_48MS = 6'd48;

  function automatic qualClass_e qualClass(input logic [4:0] code, input logic downstream);
    case (code)
      detectQuiet:   return qualDetQuiet;
      detectActive:  return qualDetActive;
      recoverySpeed: return qualSpeed;
      L0:            return downstream ? qualCount : qualFail;
      pollingActive, pollingConfiguration, cfgLinkWidthStart, cfgLinkWidthAccept,
      cfgLanenumWait, cfgLanenumAccept, cfgComplete, cfgIdle, recoveryRcvrLock,
      recoveryRcvrCfg, recoveryIdle, recoverySpeedEIEOS, phase0, phase1, phase2,
      phase3:        return qualCount;
      default:       return qualFail;
    endcase
  endfunction

  function automatic int unsigned targetCount(input logic [4:0] code, input int unsigned pipeWidth);
    case (code)
      pollingActive, cfgComplete, pollingConfiguration, recoveryRcvrLock,
      recoveryRcvrCfg:                  return 8;
      cfgLinkWidthStart, cfgLinkWidthAccept, cfgLanenumWait, cfgLanenumAccept,
      phase0, phase1, phase2, phase3:   return 2;
      cfgIdle, recoveryIdle:            return 64 / pipeWidth;
      recoverySpeed, recoverySpeedEIEOS,
      L0:                               return 1;
      default:                          return 0;
    endcase
  endfunction

  function automatic logic [MS_W-1:0] timeoutLimit(input logic [4:0] code);
    case (code)
      pollingActive, cfgComplete, cfgLinkWidthStart, cfgLinkWidthAccept,
      cfgLanenumAccept, phase0, phase1, phase2, phase3: return LIMIT_24MS;
      cfgLanenumWait, cfgIdle, recoveryIdle:            return LIMIT_2MS;
      pollingConfiguration, recoveryRcvrLock, recoveryRcvrCfg, recoverySpeed,
      recoverySpeedEIEOS, L0:                           return LIMIT_48MS;
      detectQuiet:                                      return LIMIT_12MS;
      default:                                          return LIMIT_0MS;
    endcase
  endfunction

  function automatic logic [4:0] exitCode(input logic [4:0] code, input logic [2:0] gen,
                                          input logic toIdle, input logic eqRedo);
    if (toIdle) return recoveryIdle;
    if (code == phase1 && eqRedo) return recoveryRcvrLock;
    case (code)
      recoveryIdle:       return L0;
      recoverySpeed:      return recoveryWait;
      recoverySpeedEIEOS: return (gen < 3'd3) ? recoveryRcvrLock : phase0;
      default:            return code + 5'd1;
    endcase
  endfunction

  // Legal narrowed link: lane 0 upward, power-of-two width.
  function automatic logic isDegradeWidth(input logic [15:0] ok);
    return ok inside {16'h0001, 16'h0003, 16'h000F, 16'h00FF, 16'hFFFF};
  endfunction

endpackage

// File: rtl/rx_substate_sequencer_if.sv
// Request/result and per-lane OS status bundle between the LTSSM, the RX OS
// checkers and rx_substate_sequencer.
interface rx_substate_sequencer_if #(
  parameter int unsigned MAXLANES = 16
);
  logic                req;
  logic [4:0]          substate;
  logic [2:0]          train_to_gen;
  logic [MAXLANES-1:0] lane_mask;
  logic [MAXLANES-1:0] os_hit;
  logic [MAXLANES-1:0] os_mismatch;
  logic                rx_elec_idle;
  logic                rcvr_cfg_to_idle;
  logic                eq_redo;
  logic                busy;
  logic                done;
  logic                pass;
  logic [4:0]          exit_to;
  logic [MAXLANES-1:0] lanes_ok;

  modport master (
    output req, substate, train_to_gen, lane_mask, os_hit, os_mismatch,
           rx_elec_idle, rcvr_cfg_to_idle, eq_redo,
    input  busy, done, pass, exit_to, lanes_ok
  );

  modport slave (
    input  req, substate, train_to_gen, lane_mask, os_hit, os_mismatch,
           rx_elec_idle, rcvr_cfg_to_idle, eq_redo,
    output busy, done, pass, exit_to, lanes_ok
  );
endinterface

// File: rtl/rx_ms_timer.sv
// Millisecond timer: cycle prescaler feeding a saturating ms counter; timeout
// is high while the ms count equals limit.
module rx_ms_timer #(
  parameter int unsigned TICKS_PER_MS = 1000,
  parameter int          MS_W         = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [MS_W-1:0] limit,
  output logic            timeout
);
  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PRE_W-1:0] prescale;
  logic [MS_W-1:0]  msCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      msCount  <= '0;
    end else if (clear) begin
      prescale <= '0;
      msCount  <= '0;
    end else if (prescale == PRE_W'(TICKS_PER_MS - 1)) begin
      prescale <= '0;
      if (msCount != '1) msCount <= msCount + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign timeout = (msCount == limit);

endmodule

// File: rtl/rx_substate_sequencer.sv
// Per-request RX qualifier for the LTSSM: per-lane OS counters, ms timeout and
// pass/exit decision. Optional link narrowing at timeout: RX_SEQ_WIDTH_DEGRADE_EN.
module rx_substate_sequencer
  import pcie_ltssm_pkg::*;
#(
  parameter int unsigned MAXLANES     = 16,
  parameter int unsigned TICKS_PER_MS = 1000,
  parameter int          CNT_W        = 5,
  parameter int unsigned PIPEWIDTH    = 8,
  parameter int          DEVICETYPE   = 0
) (
  input logic                   clk,
  input logic                   reset,
  rx_substate_sequencer_if.slave bus
);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  seqState_e           state;
  logic                busy, done, pass;
  logic [4:0]          exitTo;
  logic [MAXLANES-1:0] lanesOk;
  logic [4:0]          capSubstate;
  logic [2:0]          capGen;
  logic [MAXLANES-1:0] capMask;

  qualClass_e          qualKind;
  int unsigned         tgtFull;
  logic [CNT_W-1:0]    target;
  logic [MS_W-1:0]     msLimit;
  logic                timeout;
  logic                armClear;
  logic [MAXLANES-1:0] laneOk;
  logic [MAXLANES-1:0] maskedOk;
  logic                allOk, degradeOk, finish, passNow;

  always_comb begin
    qualKind = qualClass(capSubstate, DEVICETYPE == 1);
    tgtFull  = targetCount(capSubstate, PIPEWIDTH);
    target   = (tgtFull > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(tgtFull);
    msLimit  = timeoutLimit(capSubstate);
  end

  assign armClear = (state == stArm);

  rx_ms_timer #(
    .TICKS_PER_MS(TICKS_PER_MS),
    .MS_W        (MS_W)
  ) uTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (armClear),
    .limit  (msLimit),
    .timeout(timeout)
  );

  // Per-lane consecutive-OS counters; a mismatch beats a same-cycle hit.
  for (genvar g = 0; g < int'(MAXLANES); g++) begin : gLane
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (state == stArm) begin
        cnt <= '0;
      end else if (state == stCount) begin
        if (bus.os_mismatch[g]) cnt <= '0;
        else if (bus.os_hit[g] && cnt < target) cnt <= cnt + 1'b1;
      end
    end
    assign laneOk[g] = (cnt >= target);
  end

  assign maskedOk = laneOk & capMask;
  assign allOk    = (capMask != '0) && (maskedOk == capMask);
`ifdef RX_SEQ_WIDTH_DEGRADE_EN
  assign degradeOk = isDegradeWidth(16'(maskedOk));
`else
  assign degradeOk = 1'b0;
`endif

  always_comb begin
    finish  = 1'b0;
    passNow = 1'b0;
    case (qualKind)
      qualFail: finish = 1'b1;
      qualDetActive: begin
        finish  = timeout;
        passNow = timeout;
      end
      qualDetQuiet: begin
        finish  = !bus.rx_elec_idle || timeout;
        passNow = finish;
      end
      // Electrical-idle dwell: only judged once the full timeout has elapsed.
      qualSpeed: begin
        if (capMask == '0) begin
          finish = 1'b1;
        end else if (timeout) begin
          finish  = 1'b1;
          passNow = allOk || degradeOk;
        end
      end
      default: begin
        if (capMask == '0) begin
          finish = 1'b1;
        end else if (allOk) begin
          finish  = 1'b1;
          passNow = 1'b1;
        end else if (timeout) begin
          finish  = 1'b1;
          passNow = degradeOk;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= stIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      exitTo      <= '0;
      lanesOk     <= '0;
      capSubstate <= '0;
      capGen      <= '0;
      capMask     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        stIdle: begin
          if (bus.req) begin
            state       <= stArm;
            busy        <= 1'b1;
            capSubstate <= bus.substate;
            capGen      <= bus.train_to_gen;
            capMask     <= bus.lane_mask;
          end
        end
        stArm: state <= stCount;
        stCount: begin
          if (finish) begin
            state   <= passNow ? stPass : stFail;
            done    <= 1'b1;
            pass    <= passNow;
            exitTo  <= passNow ? exitCode(capSubstate, capGen, bus.rcvr_cfg_to_idle, bus.eq_redo)
                               : 5'(detectQuiet);
            lanesOk <= maskedOk;
          end
        end
        stPass, stFail: begin
          state <= stIdle;
          busy  <= 1'b0;
        end
        default: state <= stIdle;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.exit_to  = exitTo;
  assign bus.lanes_ok = lanesOk;

endmodule
